// File: rtl/karatsuba_mul64_if.sv
`default_nettype none
// ============================================================================
// Module      : karatsuba_mul64_if
// Description : Operand/result bundle for the karatsuba_mul64 multiplier.
//               With KARATSUBA_VALID_EN defined, in_valid/out_valid are added.
// Revision    : 1.0 - initial release
// ============================================================================
interface karatsuba_mul64_if #(
    parameter int HALF_W = 32
);
    logic [2*HALF_W-1:0] Xin;
    logic [2*HALF_W-1:0] Yin;
    logic [4*HALF_W-1:0] P;
    logic [2*HALF_W-1:0] high;
    logic [2*HALF_W-1:0] low;
    logic [2*HALF_W:0]   mid;
`ifdef KARATSUBA_VALID_EN
    logic                in_valid;
    logic                out_valid;

    modport master (
        output Xin, Yin, in_valid,
        input  P, high, low, mid, out_valid
    );
    modport slave (
        input  Xin, Yin, in_valid,
        output P, high, low, mid, out_valid
    );
`else
    modport master (
        output Xin, Yin,
        input  P, high, low, mid
    );
    modport slave (
        input  Xin, Yin,
        output P, high, low, mid
    );
`endif
endinterface
`default_nettype wire

// File: rtl/karatsuba_mul64.sv
`default_nettype none
// ============================================================================
// Module      : karatsuba_mul64
// Description : Three-stage pipelined unsigned 2H x 2H -> 4H multiplier using
//               one level of Karatsuba over H-bit halves. Exposes the high,
//               low and mid partial products alongside the full product.
//               Optional feature macro: KARATSUBA_VALID_EN (adds in_valid /
//               out_valid tracking the data pipeline).
// Revision    : 1.0 - initial release
// ============================================================================
module karatsuba_mul64 #(
    parameter int HALF_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    karatsuba_mul64_if.slave  bus
);

    // Stage 1: split operands and form the half sums
    logic [HALF_W-1:0]     xh_d, xh_q, xl_d, xl_q;
    logic [HALF_W-1:0]     yh_d, yh_q, yl_d, yl_q;
    logic [HALF_W:0]       sx_d, sx_q, sy_d, sy_q;

    // Stage 2: the three Karatsuba products
    logic [2*HALF_W-1:0]   hh_d, hh_q, ll_d, ll_q;
    logic [2*HALF_W+1:0]   ss_d, ss_q;

    // Stage 3: recombination and outputs
    logic [2*HALF_W+1:0]   mid_full;
    logic [2*HALF_W-1:0]   high_d, high_q, low_d, low_q;
    logic [2*HALF_W:0]     mid_d, mid_q;
    logic [4*HALF_W-1:0]   p_d, p_q;

`ifdef KARATSUBA_VALID_EN
    logic                  v1_d, v1_q, v2_d, v2_q, v3_d, v3_q;
`endif

    // Split the incoming operands and compute the (H+1)-bit half sums
    always_comb begin
        xh_d = bus.Xin[2*HALF_W-1:HALF_W];
        xl_d = bus.Xin[HALF_W-1:0];
        yh_d = bus.Yin[2*HALF_W-1:HALF_W];
        yl_d = bus.Yin[HALF_W-1:0];
        sx_d = {1'b0, bus.Xin[2*HALF_W-1:HALF_W]} + {1'b0, bus.Xin[HALF_W-1:0]};
        sy_d = {1'b0, bus.Yin[2*HALF_W-1:HALF_W]} + {1'b0, bus.Yin[HALF_W-1:0]};
    end

    // Three multiplies; operands are zero-extended so each product is exact
    always_comb begin
        hh_d = {{HALF_W{1'b0}}, xh_q} * {{HALF_W{1'b0}}, yh_q};
        ll_d = {{HALF_W{1'b0}}, xl_q} * {{HALF_W{1'b0}}, yl_q};
        ss_d = {{(HALF_W+1){1'b0}}, sx_q} * {{(HALF_W+1){1'b0}}, sy_q};
    end

    // Recover the cross term and assemble the full product. The subtraction
    // is never negative; its top bit is always zero but is kept in the sum
    // so the product assembly stays full width.
    always_comb begin
        mid_full = ss_q - {2'b00, hh_q} - {2'b00, ll_q};
        high_d   = hh_q;
        low_d    = ll_q;
        mid_d    = mid_full[2*HALF_W:0];
        p_d      = {hh_q, {(2*HALF_W){1'b0}}}
                 + {{(HALF_W-2){1'b0}}, mid_full, {HALF_W{1'b0}}}
                 + {{(2*HALF_W){1'b0}}, ll_q};
    end

`ifdef KARATSUBA_VALID_EN
    // Valid bit rides alongside the data, one flop per stage
    always_comb begin
        v1_d = bus.in_valid;
        v2_d = v1_q;
        v3_d = v2_q;
    end
`endif

    // Pipeline registers; reset flushes every stage so no partial result escapes
    always_ff @(posedge clock) begin
        if (reset) begin
            xh_q   <= '0;
            xl_q   <= '0;
            yh_q   <= '0;
            yl_q   <= '0;
            sx_q   <= '0;
            sy_q   <= '0;
            hh_q   <= '0;
            ll_q   <= '0;
            ss_q   <= '0;
            high_q <= '0;
            low_q  <= '0;
            mid_q  <= '0;
            p_q    <= '0;
`ifdef KARATSUBA_VALID_EN
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
`endif
        end else begin
            xh_q   <= xh_d;
            xl_q   <= xl_d;
            yh_q   <= yh_d;
            yl_q   <= yl_d;
            sx_q   <= sx_d;
            sy_q   <= sy_d;
            hh_q   <= hh_d;
            ll_q   <= ll_d;
            ss_q   <= ss_d;
            high_q <= high_d;
            low_q  <= low_d;
            mid_q  <= mid_d;
            p_q    <= p_d;
`ifdef KARATSUBA_VALID_EN
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            v3_q   <= v3_d;
`endif
        end
    end

    assign bus.P    = p_q;
    assign bus.high = high_q;
    assign bus.low  = low_q;
    assign bus.mid  = mid_q;
`ifdef KARATSUBA_VALID_EN
    assign bus.out_valid = v3_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_karatsuba_mul64.sv
`default_nettype none
// ============================================================================
// Module      : tb_karatsuba_mul64
// Description : Self-checking bench for karatsuba_mul64. Directed corner
//               cases plus a long random stream with a mid-stream reset,
//               checked against a plain-arithmetic reference model.
//               Honours KARATSUBA_VALID_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_karatsuba_mul64;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int   n_vec  = 0;
    int   n_fail = 0;

    // Input history, one entry per rising edge
    logic [63:0] hx[$];
    logic [63:0] hy[$];
    logic        hr[$];
    logic        hv[$];

    always #5 clk = ~clk;

    karatsuba_mul64_if #(.HALF_W(32)) bus ();

    karatsuba_mul64 #(.HALF_W(32)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply one input set for one edge, then compare all outputs with the model
    task automatic step(input logic [63:0] x, input logic [63:0] y, input logic r, input logic v);
        int          k;
        logic        ok;
        logic [63:0] ex, ey;
        logic [31:0] xh, xl, yh, yl;
        logic [127:0] e_p;
        logic [63:0] e_h, e_l;
        logic [64:0] e_m;
        @(negedge clk);
        bus.Xin = x;
        bus.Yin = y;
        rst     = r;
`ifdef KARATSUBA_VALID_EN
        bus.in_valid = v;
`endif
        @(posedge clk);
        hx.push_back(x);
        hy.push_back(y);
        hr.push_back(r);
        hv.push_back(v);
        #1;
        k  = hx.size() - 1;
        ok = (k >= 2) && !hr[k] && !hr[k-1] && !hr[k-2];
        ex = ok ? hx[k-2] : 64'd0;
        ey = ok ? hy[k-2] : 64'd0;
        xh = ex[63:32];
        xl = ex[31:0];
        yh = ey[63:32];
        yl = ey[31:0];
        e_p = {64'd0, ex} * {64'd0, ey};
        e_h = {32'd0, xh} * {32'd0, yh};
        e_l = {32'd0, xl} * {32'd0, yl};
        e_m = {33'd0, xh} * {33'd0, yl} + {33'd0, xl} * {33'd0, yh};
        chk("P",    bus.P,                 e_p);
        chk("high", {64'd0, bus.high},     {64'd0, e_h});
        chk("low",  {64'd0, bus.low},      {64'd0, e_l});
        chk("mid",  {63'd0, bus.mid},      {63'd0, e_m});
`ifdef KARATSUBA_VALID_EN
        chk("out_valid", {127'd0, bus.out_valid}, {127'd0, ok && hv[k-2]});
`endif
    endtask

    // Issue one pair, hold the follow-up pair for two more edges, then
    // compare against literal golden values
    task automatic directed(input string tag,
                            input logic [63:0] x,  input logic [63:0] y,
                            input logic [63:0] nx, input logic [63:0] ny,
                            input logic [127:0] g_p, input logic [63:0] g_h,
                            input logic [63:0] g_l, input logic [64:0] g_m);
        step(x, y, 1'b0, 1'b1);
        step(nx, ny, 1'b0, 1'b1);
        step(nx, ny, 1'b0, 1'b1);
        chk({tag, ".P"},    bus.P,             g_p);
        chk({tag, ".high"}, {64'd0, bus.high}, {64'd0, g_h});
        chk({tag, ".low"},  {64'd0, bus.low},  {64'd0, g_l});
        chk({tag, ".mid"},  {63'd0, bus.mid},  {63'd0, g_m});
    endtask

    initial begin
        logic [63:0] rx, ry;
        bus.Xin = '0;
        bus.Yin = '0;
`ifdef KARATSUBA_VALID_EN
        bus.in_valid = 1'b0;
`endif
        // Reset flush with live operands on the bus
        step(64'h972a846916419f82, 64'h9a1de644815ef6d1, 1'b1, 1'b1);
        step(64'h972a846916419f82, 64'h9a1de644815ef6d1, 1'b1, 1'b1);
        chk("rst.P", bus.P, 128'd0);
        for (int i = 0; i < 3; i++)
            step(64'h972a846916419f82, 64'h9a1de644815ef6d1, 1'b0, 1'b1);

        directed("cross", 64'h0000000100000000, 64'h1, 64'd0, 64'd0,
                 128'h100000000, 64'd0, 64'd0, 65'd1);
        directed("max", {64{1'b1}}, {64{1'b1}}, 64'd5, 64'd7,
                 128'hFFFFFFFFFFFFFFFE0000000000000001,
                 64'hFFFFFFFE00000001, 64'hFFFFFFFE00000001,
                 65'h1FFFFFFFC00000002);
        directed("small", 64'd2, 64'd3, 64'd0, 64'd3,
                 128'd6, 64'd0, 64'd6, 65'd0);
        step(64'd0, 64'd3, 1'b0, 1'b1);
        chk("zero.P", bus.P, 128'd0);

        // Back-to-back random stream with a reset burst in the middle
        for (int i = 0; i < 1000; i++) begin
            rx = {$urandom(), $urandom()};
            ry = {$urandom(), $urandom()};
            if (i % 97 == 5)  rx = '1;
            if (i % 89 == 11) ry = '0;
            step(rx, ry, (i == 500 || i == 501), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 3; i++)
            step(64'd0, 64'd0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
